// File: rtl/weight_ctrl_pkg.sv
// Shared types and helpers for the per-neuron weight memory controller.
package weight_ctrl_pkg;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        LOADING = 2'd1,
        READY   = 2'd2
    } wstate_e;

    // Index of the final weight in a neuron's memory.
    function automatic int last_idx(input int num_weight);
        return num_weight - 1;
    endfunction

endpackage

// File: rtl/wrap_counter.sv
// Enable-driven up counter that wraps to zero after MAX, with synchronous clear.
module wrap_counter #(
    parameter int WIDTH = 10,
    parameter int MAX   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             at_max
);

    logic [WIDTH-1:0] count_r;

    assign count  = count_r;
    assign at_max = (count_r == WIDTH'(MAX));

    // Count register: wraps by comparison against MAX, not by overflow.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count_r <= '0;
        end else if (en) begin
            count_r <= at_max ? '0 : count_r + WIDTH'(1);
        end else begin
            count_r <= count_r;
        end
    end

endmodule

// File: rtl/weight_mem_ctrl.sv
// Per-neuron Weight_Memory sequencer: ID-filtered loading and latency-aligned reads.
// Define WEIGHT_PRETRAINED_EN for ROM-initialised weights (no runtime loading).
module weight_mem_ctrl
    import weight_ctrl_pkg::*;
#(
    parameter int numWeight    = 3,
    parameter int neuronNo     = 5,
    parameter int layerNo      = 1,
    parameter int addressWidth = 10,
    parameter int dataWidth    = 16,
    parameter int idWidth      = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cfg_valid,
    output logic                    cfg_ready,
    input  logic [idWidth-1:0]      cfg_layer,
    input  logic [idWidth-1:0]      cfg_neuron,
    input  logic [dataWidth-1:0]    cfg_data,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [dataWidth-1:0]    in_data,
    output logic                    mem_wen,
    output logic [addressWidth-1:0] mem_wadd,
    output logic [dataWidth-1:0]    mem_win,
    output logic                    mem_ren,
    output logic [addressWidth-1:0] mem_radd,
    output logic                    out_valid,
    output logic [dataWidth-1:0]    out_data,
    output logic                    out_last,
    output logic                    loaded
);

    localparam int LAST_IDX = last_idx(numWeight);

    wstate_e                 state_r;
    wstate_e                 state_next_s;
    logic                    match_s;
    logic                    cfg_ready_s;
    logic                    wen_s;
    logic                    in_ready_s;
    logic                    ren_s;
    logic [addressWidth-1:0] rd_ptr_s;
    logic                    rd_at_max_s;
    logic                    out_valid_r;
    logic [dataWidth-1:0]    out_data_r;
    logic                    out_last_r;
    logic                    loaded_r;

    assign match_s = (cfg_layer == idWidth'(layerNo)) && (cfg_neuron == idWidth'(neuronNo));

`ifdef WEIGHT_PRETRAINED_EN
    localparam wstate_e RESET_STATE = READY;

    assign mem_wadd = '0;

    // ROM-backed weights: the bus is always drained and nothing is written.
    always_comb begin
        cfg_ready_s  = 1'b1;
        wen_s        = 1'b0;
        in_ready_s   = (state_r == READY);
        state_next_s = state_r;
    end
`else
    localparam wstate_e RESET_STATE = EMPTY;

    logic wr_at_max_s;

    wrap_counter #(
        .WIDTH (addressWidth),
        .MAX   (LAST_IDX)
    ) u_wr_ptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .en     (wen_s),
        .count  (mem_wadd),
        .at_max (wr_at_max_s)
    );

    // Handshakes and next state; a reload is only accepted at a frame boundary.
    always_comb begin
        cfg_ready_s  = 1'b1;
        wen_s        = 1'b0;
        in_ready_s   = 1'b0;
        state_next_s = state_r;
        case (state_r)
            EMPTY: begin
                wen_s = cfg_valid && match_s;
                if (wen_s) begin
                    state_next_s = (LAST_IDX == 0) ? READY : LOADING;
                end else begin
                    state_next_s = EMPTY;
                end
            end
            LOADING: begin
                wen_s = cfg_valid && match_s;
                if (wen_s && wr_at_max_s) begin
                    state_next_s = READY;
                end else begin
                    state_next_s = LOADING;
                end
            end
            READY: begin
                cfg_ready_s = !match_s || (rd_ptr_s == '0);
                wen_s       = cfg_valid && cfg_ready_s && match_s;
                in_ready_s  = !wen_s;
                if (wen_s) begin
                    state_next_s = (LAST_IDX == 0) ? READY : LOADING;
                end else begin
                    state_next_s = READY;
                end
            end
            default: begin
                cfg_ready_s  = 1'b1;
                wen_s        = 1'b0;
                in_ready_s   = 1'b0;
                state_next_s = EMPTY;
            end
        endcase
    end
`endif

    assign ren_s = in_valid && in_ready_s;

    wrap_counter #(
        .WIDTH (addressWidth),
        .MAX   (LAST_IDX)
    ) u_rd_ptr (
        .clk    (clk),
        .rst    (rst),
        .clr    (1'b0),
        .en     (ren_s),
        .count  (rd_ptr_s),
        .at_max (rd_at_max_s)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= RESET_STATE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Outputs re-timed by one cycle to line up with the memory's read data.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            loaded_r    <= (RESET_STATE == READY);
        end else begin
            out_valid_r <= ren_s;
            out_data_r  <= ren_s ? in_data : out_data_r;
            out_last_r  <= ren_s && rd_at_max_s;
            loaded_r    <= (state_next_s == READY);
        end
    end

    assign cfg_ready = cfg_ready_s;
    assign in_ready  = in_ready_s;
    assign mem_wen   = wen_s;
    assign mem_win   = cfg_data;
    assign mem_ren   = ren_s;
    assign mem_radd  = rd_ptr_s;
    assign out_valid = out_valid_r;
    assign out_data  = out_data_r;
    assign out_last  = out_last_r;
    assign loaded    = loaded_r;

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Directed self-checking bench for weight_mem_ctrl (numWeight=3, neuron 5, layer 1).
module tb_weight_mem_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [7:0]  cfg_layer;
    logic [7:0]  cfg_neuron;
    logic [15:0] cfg_data;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        mem_wen;
    logic [9:0]  mem_wadd;
    logic [15:0] mem_win;
    logic        mem_ren;
    logic [9:0]  mem_radd;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_last;
    logic        loaded;

    int errors = 0;
    int checks = 0;

    weight_mem_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_layer  (cfg_layer),
        .cfg_neuron (cfg_neuron),
        .cfg_data   (cfg_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mem_wen    (mem_wen),
        .mem_wadd   (mem_wadd),
        .mem_win    (mem_win),
        .mem_ren    (mem_ren),
        .mem_radd   (mem_radd),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_last   (out_last),
        .loaded     (loaded)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    // Advance one clock and settle past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg(input logic v, input logic [7:0] nrn, input logic [15:0] d);
        cfg_valid  = v;
        cfg_layer  = 8'd1;
        cfg_neuron = nrn;
        cfg_data   = d;
    endtask

    initial begin
        rst = 1'b1; cfg(1'b0, 8'd5, 16'h0); in_valid = 1'b0; in_data = 16'h0;
        tick(); tick();
        chk("rst_loaded", loaded, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_in_ready", in_ready, 0);
        rst = 1'b0;

        // Load A, (non-matching), B, C
        cfg(1'b1, 8'd5, 16'h000A); #1;
        chk("ld0_wen", mem_wen, 1);
        chk("ld0_wadd", mem_wadd, 0);
        chk("ld0_win", mem_win, 16'h000A);
        chk("ld0_in_ready", in_ready, 0);
        tick();
        cfg(1'b1, 8'd4, 16'h0099); #1;
        chk("nm_cfg_ready", cfg_ready, 1);
        chk("nm_wen", mem_wen, 0);
        chk("nm_wadd", mem_wadd, 1);
        tick();
        cfg(1'b1, 8'd5, 16'h000B); #1;
        chk("ld1_wen", mem_wen, 1);
        chk("ld1_wadd", mem_wadd, 1);
        tick();
        cfg(1'b1, 8'd5, 16'h000C); #1;
        chk("ld2_wen", mem_wen, 1);
        chk("ld2_wadd", mem_wadd, 2);
        chk("ld2_loaded", loaded, 0);
        chk("ld2_in_ready", in_ready, 0);
        tick();
        cfg(1'b0, 8'd5, 16'h0); #1;
        chk("ready_loaded", loaded, 1);
        chk("ready_in_ready", in_ready, 1);
        chk("ready_cfg_ready", cfg_ready, 1);

        // Six back-to-back samples
        for (int i = 1; i <= 6; i++) begin
            in_valid = 1'b1; in_data = 16'(i); #1;
            chk("b2b_ren", mem_ren, 1);
            chk("b2b_radd", mem_radd, 32'((i - 1) % 3));
            tick();
            chk("b2b_out_valid", out_valid, 1);
            chk("b2b_out_data", out_data, 32'(i));
            chk("b2b_out_last", out_last, (i % 3 == 0) ? 32'd1 : 32'd0);
        end
        in_valid = 1'b0;
        tick();
        chk("idle_out_valid", out_valid, 0);
        chk("idle_out_last", out_last, 0);
        chk("idle_out_data_hold", out_data, 6);

        // Gapped samples: valid, idle, valid, valid
        in_valid = 1'b1; in_data = 16'h0011; #1;
        chk("gap0_radd", mem_radd, 0);
        tick();
        chk("gap0_out_valid", out_valid, 1);
        chk("gap0_out_data", out_data, 16'h0011);
        in_valid = 1'b0; in_data = 16'h0012; #1;
        chk("gap1_ren", mem_ren, 0);
        chk("gap1_radd", mem_radd, 1);
        tick();
        chk("gap1_out_valid", out_valid, 0);
        chk("gap1_out_data", out_data, 16'h0011);
        in_valid = 1'b1; in_data = 16'h0013; #1;
        chk("gap2_radd", mem_radd, 1);
        tick();
        chk("gap2_out_data", out_data, 16'h0013);
        in_data = 16'h0014; #1;
        chk("gap3_radd", mem_radd, 2);
        tick();
        chk("gap3_out_valid", out_valid, 1);
        chk("gap3_out_last", out_last, 1);

        // Move to mid-frame (rd_ptr=1), then try to reload
        in_data = 16'h0021; tick();
        in_valid = 1'b0;
        cfg(1'b1, 8'd5, 16'h000D); #1;
        chk("mid_cfg_ready", cfg_ready, 0);
        chk("mid_wen", mem_wen, 0);
        chk("mid_in_ready", in_ready, 1);
        cfg(1'b1, 8'd4, 16'h000D); #1;
        chk("mid_nm_cfg_ready", cfg_ready, 1);
        chk("mid_nm_wen", mem_wen, 0);
        tick();
        cfg(1'b1, 8'd5, 16'h000D);
        in_valid = 1'b1; in_data = 16'h0022; #1;
        chk("mid2_cfg_ready", cfg_ready, 0);
        chk("mid2_radd", mem_radd, 1);
        tick();
        in_data = 16'h0023; #1;
        chk("mid3_cfg_ready", cfg_ready, 0);
        chk("mid3_radd", mem_radd, 2);
        tick();
        chk("mid3_out_last", out_last, 1);

        // Frame boundary: config wins over simultaneous sample
        in_data = 16'h0024; #1;
        chk("bnd_cfg_ready", cfg_ready, 1);
        chk("bnd_wen", mem_wen, 1);
        chk("bnd_wadd", mem_wadd, 0);
        chk("bnd_in_ready", in_ready, 0);
        chk("bnd_ren", mem_ren, 0);
        tick();
        chk("bnd_loaded", loaded, 0);
        chk("bnd_out_valid", out_valid, 0);
        chk("bnd_in_ready_loading", in_ready, 0);
        in_valid = 1'b0;
        cfg(1'b1, 8'd5, 16'h000E); #1;
        chk("rl1_wadd", mem_wadd, 1);
        tick();

        // Reset mid-load after two writes
        cfg(1'b0, 8'd5, 16'h0); rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mrst_loaded", loaded, 0);
        cfg(1'b1, 8'd5, 16'h000F); #1;
        chk("mrst_wen", mem_wen, 1);
        chk("mrst_wadd", mem_wadd, 0);
        tick();
        cfg(1'b0, 8'd5, 16'h0); #1;
        chk("mrst_loaded_after", loaded, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
